// File: rtl/ws2812_controller.sv
// rtl/ws2812_controller.sv - WS2812 LED strip controller with a 4-register CPU port
// Optional DATA readback port enabled by defining WS2812_READBACK_EN.
module ws2812_controller #(
  parameter int NUM_LEDS     = 16,
  parameter int BIT_CYCLES   = 25,
  parameter int T0H_CYCLES   = 8,
  parameter int T1H_CYCLES   = 16,
  parameter int RESET_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] addr,
  input  logic       ws2812_io_req,
  input  logic       ws2812_io_wr,
  input  logic [7:0] ws2812_data_in,
  output logic [7:0] ws2812_data_out,
  output logic       ws2812_tx,
  output logic       ws2812_busy
);

  localparam int IW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CMAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] T0L_LAST   = CW'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1L_LAST   = CW'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_LATCH} state_t;

  state_t        state, state_n;
  logic [IW-1:0] index;
  logic [1:0]    sub;
  logic [7:0]    count;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [IW-1:0] led_idx;
  logic [IW-1:0] frame_last;
  logic [23:0]   shift;

  logic [7:0] mem_g [NUM_LEDS];
  logic [7:0] mem_r [NUM_LEDS];
  logic [7:0] mem_b [NUM_LEDS];

  logic wr_en, rd_en, data_wr, start_req, ptr_adv;
  logic [7:0] rd_byte;

  assign wr_en     = ws2812_io_req & ws2812_io_wr;
  assign rd_en     = ws2812_io_req & ~ws2812_io_wr;
  assign data_wr   = wr_en && (addr == 2'd1);
  assign start_req = wr_en && (addr == 2'd2) && ws2812_data_in[0];

`ifdef WS2812_READBACK_EN
  assign ptr_adv = data_wr | (rd_en && (addr == 2'd1));
  always_comb begin
    rd_byte = mem_b[index];
    if (sub == 2'd0)      rd_byte = mem_g[index];
    else if (sub == 2'd1) rd_byte = mem_r[index];
  end
`else
  assign ptr_adv = data_wr;
  assign rd_byte = 8'h00;
`endif

  // Pixel storage has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (data_wr) begin
      case (sub)
        2'd0:    mem_g[index] <= ws2812_data_in;
        2'd1:    mem_r[index] <= ws2812_data_in;
        default: mem_b[index] <= ws2812_data_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index           <= '0;
      sub             <= 2'd0;
      count           <= 8'd0;
      ws2812_data_out <= 8'd0;
    end else begin
      if (wr_en && (addr == 2'd0)) begin
        index <= ({1'b0, ws2812_data_in} < 9'(NUM_LEDS)) ? IW'(ws2812_data_in) : '0;
        sub   <= 2'd0;
      end else if (ptr_adv) begin
        if (sub == 2'd2) begin
          sub   <= 2'd0;
          index <= (index == LAST_IDX) ? '0 : index + 1'b1;
        end else begin
          sub <= sub + 2'd1;
        end
      end
      if (wr_en && (addr == 2'd3)) count <= ws2812_data_in;
      if (rd_en) begin
        case (addr)
          2'd0:    ws2812_data_out <= 8'(index);
          2'd1:    ws2812_data_out <= rd_byte;
          2'd2:    ws2812_data_out <= {7'b0, ws2812_busy};
          default: ws2812_data_out <= count;
        endcase
      end
    end
  end

  logic          cur_bit, last_bit, last_led;
  logic [CW-1:0] hi_last, lo_last, lo_pre;

  assign cur_bit  = shift[23];
  assign last_bit = (bit_cnt == 5'd23);
  assign last_led = (led_idx == frame_last);
  assign hi_last  = cur_bit ? T1H_LAST : T0H_LAST;
  assign lo_last  = cur_bit ? T1L_LAST : T0L_LAST;
  // Next LED is fetched one cycle early so the LOAD cycle is part of the low time.
  assign lo_pre   = lo_last - 1'b1;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_req) state_n = S_LOAD;
      S_LOAD:  state_n = S_HIGH;
      S_HIGH:  if (cnt == hi_last) state_n = S_LOW;
      S_LOW: begin
        if (last_bit && !last_led && (cnt == lo_pre)) state_n = S_LOAD;
        else if (cnt == lo_last) state_n = last_bit ? S_LATCH : S_HIGH;
      end
      S_LATCH: if (cnt == LATCH_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= 5'd0;
      led_idx     <= '0;
      frame_last  <= '0;
      shift       <= 24'd0;
      ws2812_tx   <= 1'b0;
      ws2812_busy <= 1'b0;
    end else begin
      state       <= state_n;
      ws2812_tx   <= (state_n == S_HIGH);
      ws2812_busy <= (state_n != S_IDLE);
      cnt         <= ((state_n != state) || (state_n == S_IDLE)) ? '0 : cnt + 1'b1;
      if ((state == S_IDLE) && (state_n == S_LOAD)) begin
        led_idx <= '0;
        if ((count == 8'd0) || ({1'b0, count} > 9'(NUM_LEDS))) frame_last <= LAST_IDX;
        else frame_last <= IW'(count - 8'd1);
      end
      if (state == S_LOAD) begin
        shift   <= {mem_g[led_idx], mem_r[led_idx], mem_b[led_idx]};
        bit_cnt <= 5'd0;
      end
      if ((state == S_LOW) && (state_n == S_HIGH)) begin
        shift   <= {shift[22:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if ((state == S_LOW) && (state_n == S_LOAD)) led_idx <= led_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_ws2812_controller.sv
// tb/tb_ws2812_controller.sv - directed self-checking bench for ws2812_controller
// Expectations follow WS2812_READBACK_EN when it is defined for the build.
module tb_ws2812_controller;

  localparam int BIT = 25;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] addr;
  logic       req, wr;
  logic [7:0] din, dout;
  logic       tx, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int hi_a [384];
  int lo_a [384];
  int rise_lat;

  ws2812_controller dut (
    .clk(clk), .reset_n(reset_n), .addr(addr),
    .ws2812_io_req(req), .ws2812_io_wr(wr), .ws2812_data_in(din),
    .ws2812_data_out(dout), .ws2812_tx(tx), .ws2812_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wr = 1'b1; din = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; wr = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    d = dout;
  endtask

  task automatic capture(input int nbits);
    int w, hi, lo;
    w = 0;
    while (!tx && w < 20) begin w++; @(negedge clk); end
    rise_lat = w;
    for (int i = 0; i < nbits; i++) begin
      hi = 0;
      while (tx && hi < 40) begin hi++; @(negedge clk); end
      lo = 0;
      while (!tx && lo < BIT) begin lo++; @(negedge clk); end
      hi_a[i] = hi;
      lo_a[i] = lo;
    end
  endtask

  task automatic wait_idle(input int t0, output int dur, output int tx_hits);
    dur = -1;
    tx_hits = 0;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin dur = cyc - t0; break; end
      if (tx) tx_hits++;
      @(negedge clk);
    end
  endtask

  function automatic logic [23:0] decode24(input int base);
    logic [23:0] w;
    w = 24'd0;
    for (int i = 0; i < 24; i++) w = {w[22:0], (hi_a[base + i] > 12)};
    return w;
  endfunction

  logic [7:0] r;
  logic [7:0] exp_rd [3];
  logic [7:0] exp_idx;
  int t0, dur, hits, bad, bad2;

  initial begin
    req = 1'b0; wr = 1'b0; addr = 2'd0; din = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_tx", 32'(tx), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    cpu_read(2'd2, r); check("rst_status", 32'(r), 32'h0);
    cpu_read(2'd0, r); check("rst_index", 32'(r), 32'h0);
    cpu_read(2'd3, r); check("rst_count", 32'(r), 32'h0);

    // Byte writes at LED2 and readback through the DATA port
`ifdef WS2812_READBACK_EN
    exp_rd[0] = 8'hFF; exp_rd[1] = 8'h00; exp_rd[2] = 8'hAA; exp_idx = 8'd3;
`else
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_idx = 8'd2;
`endif
    cpu_write(2'd0, 8'd2);
    cpu_write(2'd1, 8'hFF); cpu_write(2'd1, 8'h00); cpu_write(2'd1, 8'hAA);
    cpu_write(2'd0, 8'd2);
    for (int i = 0; i < 3; i++) begin
      cpu_read(2'd1, r);
      check($sformatf("data_rd%0d", i), 32'(r), 32'(exp_rd[i]));
    end
    cpu_read(2'd0, r); check("index_after_rd", 32'(r), 32'(exp_idx));
    cpu_write(2'd3, 8'd1);
    check("dout_hold_on_wr", 32'(dout), 32'(exp_idx));
    cpu_read(2'd3, r); check("count_rd", 32'(r), 32'h1);

    cpu_write(2'd0, 8'd20); cpu_read(2'd0, r); check("index_oor", 32'(r), 32'h0);
    cpu_write(2'd0, 8'd15); cpu_read(2'd0, r); check("index_15", 32'(r), 32'd15);

    // Pointer wrap from LED15 B to LED0 G, verified on the wire
    cpu_write(2'd0, 8'd15);
    cpu_write(2'd1, 8'h11); cpu_write(2'd1, 8'h22); cpu_write(2'd1, 8'h33); cpu_write(2'd1, 8'h44);
    cpu_read(2'd0, r); check("index_wrap", 32'(r), 32'h0);
    cpu_write(2'd1, 8'h00); cpu_write(2'd1, 8'h01);
    cpu_write(2'd2, 8'h01); t0 = cyc;
    capture(24);
    check("frameA_word", 32'(decode24(0)), 32'h440001);
    wait_idle(t0, dur, hits);
    check("frameA_busy_len", dur, 1601);

    // Single LED 0x800001 timing
    cpu_write(2'd0, 8'd0);
    cpu_write(2'd1, 8'h80); cpu_write(2'd1, 8'h00); cpu_write(2'd1, 8'h01);
    cpu_write(2'd2, 8'h01); t0 = cyc;
    check("start_busy", 32'(busy), 32'h1);
    check("load_tx_low", 32'(tx), 32'h0);
    capture(24);
    check("first_high_lat", rise_lat, 1);
    check("bit0_high", hi_a[0], 16);
    bad = 0;
    for (int i = 1; i < 23; i++) if (hi_a[i] != 8) bad++;
    check("mid_bits_high", bad, 0);
    check("bit23_high", hi_a[23], 16);
    bad = 0;
    for (int i = 0; i < 23; i++) if (hi_a[i] + lo_a[i] != BIT) bad++;
    check("bit_periods", bad, 0);
    wait_idle(t0, dur, hits);
    check("frameB_busy_len", dur, 1601);
    check("latch_tx_low", hits, 0);

    // Start while busy must be ignored
    cpu_write(2'd2, 8'h01); t0 = cyc;
    repeat (100) @(negedge clk);
    cpu_write(2'd2, 8'h01);
    wait_idle(t0, dur, hits);
    check("restart_busy_len", dur, 1601);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy || tx) hits++;
      @(negedge clk);
    end
    check("no_second_frame", hits, 0);

    // COUNT=0 sends every LED with seamless LED boundaries
    cpu_write(2'd3, 8'd0);
    cpu_write(2'd2, 8'h01); t0 = cyc;
    capture(384);
    bad = 0; bad2 = 0;
    for (int i = 0; i < 384; i++) if (hi_a[i] != 8 && hi_a[i] != 16) bad++;
    for (int i = 0; i < 383; i++) if (hi_a[i] + lo_a[i] != BIT) bad2++;
    check("full_high_widths", bad, 0);
    check("full_periods", bad2, 0);
    wait_idle(t0, dur, hits);
    check("full_busy_len", dur, 10601);
    check("full_latch_low", hits, 0);

    // Reset in the middle of a high pulse
    cpu_write(2'd3, 8'd1);
    cpu_write(2'd2, 8'h01);
    for (int i = 0; i < 10 && !tx; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_reset_tx", 32'(tx), 32'h1);
    reset_n = 1'b0;
    #1;
    check("reset_tx", 32'(tx), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_read(2'd2, r); check("post_reset_status", 32'(r), 32'h0);
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy || tx) hits++;
      @(negedge clk);
    end
    check("no_resume", hits, 0);
    cpu_read(2'd3, r); check("post_reset_count", 32'(r), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
